// File: rtl/cvxif_vec_mv_unit.sv
// CV-X-IF coprocessor: scalar<->vector register moves (MV_V_X / MV_X_V).
// In-order retire queue with commit/kill tracking and one result register.
module cvxif_vec_mv_unit #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned QueueDepth = 4,
  parameter int unsigned NrVregs    = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [31:0]     issue_instr_i,
  input  logic [3:0]      issue_id_i,
  input  logic [XLEN-1:0] issue_rs1_i,
  input  logic            issue_rs_valid_i,
  output logic            issue_accept_o,
  output logic            issue_writeback_o,
  input  logic            commit_valid_i,
  input  logic [3:0]      commit_id_i,
  input  logic            commit_kill_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [3:0]      result_id_o,
  output logic [XLEN-1:0] result_data_o,
  output logic [4:0]      result_rd_o,
  output logic            result_we_o
);

  localparam int unsigned PW = $clog2(QueueDepth);
  localparam int unsigned VW = $clog2(NrVregs);

  typedef enum logic {
    OP_VX = 1'b0,
    OP_XV = 1'b1
  } op_e;

  typedef struct packed {
    op_e             op;
    logic [3:0]      id;
    logic [4:0]      rd;
    logic [VW-1:0]   vidx;
    logic [XLEN-1:0] rs1;
    logic            cmt;
    logic            kill;
  } entry_t;

  entry_t          r_q [QueueDepth];
  logic [QueueDepth-1:0] r_vld;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [PW:0]     r_cnt;
  logic [XLEN-1:0] r_vreg [NrVregs];

  logic            r_res_valid;
  logic [3:0]      r_res_id;
  logic [XLEN-1:0] r_res_data;
  logic [4:0]      r_res_rd;

  logic            w_is_vx;
  logic            w_is_xv;
  logic            w_acc;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_vwe;
  logic            w_rload;
  logic            w_res_free;
  logic            w_head_ok;
  entry_t          w_head;
  entry_t          w_new;
  logic [VW-1:0]   w_vd_idx;
  logic [VW-1:0]   w_vs2_idx;

  assign w_is_vx = (issue_instr_i & 32'hFE00707F) == 32'h0000000B;
  assign w_is_xv = (issue_instr_i & 32'hFE00707F) == 32'h0000100B;
  assign w_acc   = w_is_vx | w_is_xv;

  assign w_vd_idx  = VW'(32'(issue_instr_i[11:7]) % NrVregs);
  assign w_vs2_idx = VW'(32'(issue_instr_i[24:20]) % NrVregs);

  assign w_full        = r_cnt == (PW+1)'(QueueDepth);
  assign issue_ready_o = !w_full && (!w_acc || issue_rs_valid_i);
  assign w_push        = issue_valid_i & issue_ready_o & w_acc;

  assign issue_accept_o    = w_acc;
  assign issue_writeback_o = w_is_xv;

  // a commit arriving with the issue it names lands in the new entry
  always_comb begin
    w_new      = '0;
    w_new.op   = w_is_xv ? OP_XV : OP_VX;
    w_new.id   = issue_id_i;
    w_new.rd   = issue_instr_i[11:7];
    w_new.vidx = w_is_xv ? w_vs2_idx : w_vd_idx;
    w_new.rs1  = issue_rs1_i;
    w_new.cmt  = commit_valid_i & !commit_kill_i &
                 (commit_id_i == issue_id_i);
    w_new.kill = commit_valid_i & commit_kill_i &
                 (commit_id_i == issue_id_i);
  end

  assign w_head     = r_q[r_head];
  assign w_head_ok  = r_vld[r_head] & (w_head.cmt | w_head.kill);
  assign w_res_free = !r_res_valid | result_ready_i;

  always_comb begin
    w_pop   = 1'b0;
    w_vwe   = 1'b0;
    w_rload = 1'b0;
    if (w_head_ok) begin
      if (w_head.kill) begin
        w_pop = 1'b1;
      end else if (w_head.op == OP_VX) begin
        w_pop = 1'b1;
        w_vwe = 1'b1;
      end else begin
        w_pop   = w_res_free;
        w_rload = w_res_free;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld  <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < QueueDepth; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < QueueDepth; i++) begin
        if (r_vld[i] && commit_valid_i &&
            r_q[i].id == commit_id_i) begin
          if (commit_kill_i) r_q[i].kill <= 1'b1;
          else               r_q[i].cmt  <= 1'b1;
        end
      end
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PW'(1);
      end
      if (w_push) begin
        r_q[r_tail]   <= w_new;
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + PW'(1);
      end
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrVregs; i++) begin
        r_vreg[i] <= '0;
      end
    end else if (w_vwe) begin
      r_vreg[w_head.vidx] <= w_head.rs1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_data  <= '0;
      r_res_rd    <= '0;
    end else if (w_rload) begin
      r_res_valid <= 1'b1;
      r_res_id    <= w_head.id;
      r_res_data  <= r_vreg[w_head.vidx];
      r_res_rd    <= w_head.rd;
    end else if (result_ready_i) begin
      r_res_valid <= 1'b0;
    end
  end

  assign result_valid_o = r_res_valid;
  assign result_id_o    = r_res_id;
  assign result_data_o  = r_res_data;
  assign result_rd_o    = r_res_rd;
  assign result_we_o    = r_res_valid;

endmodule

// File: doc/cvxif_vec_mv_unit.md
CVXIF_VEC_MV_UNIT -- requirements
Module: cvxif_vec_mv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, scalar/vector element width in bits.
REQ-002 SHALL have parameter QueueDepth, default 4, number of accepted-but-unretired instruction slots (power of two, >=2).
REQ-003 SHALL have parameter NrVregs, default 32, number of vector registers, each one XLEN-bit element.
REQ-004 clk_i  in  1  single clock, rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 issue_valid_i  in  1  issue request valid.
REQ-007 issue_ready_o  out  1  unit can take issue this cycle.
REQ-008 issue_instr_i  in  32  offloaded instruction word.
REQ-009 issue_id_i  in  4  instruction id.
REQ-010 issue_rs1_i  in  XLEN  rs1 operand.
REQ-011 issue_rs_valid_i  in  1  rs1 operand valid.
REQ-012 issue_accept_o  out  1  instruction recognised; valid only on issue handshake.
REQ-013 issue_writeback_o  out  1  instruction will write a scalar rd; valid only on issue handshake.
REQ-014 commit_valid_i  in  1  commit/kill message valid.
REQ-015 commit_id_i  in  4  id being committed or killed.
REQ-016 commit_kill_i  in  1  1 = kill, 0 = commit.
REQ-017 result_valid_o  out  1  scalar result valid.
REQ-018 result_ready_i  in  1  core accepts result.
REQ-019 result_id_o  out  4  id of result.
REQ-020 result_data_o  out  XLEN  result data.
REQ-021 result_rd_o  out  5  destination scalar register.
REQ-022 result_we_o  out  1  write enable, 1 whenever result_valid_o=1.

Function
REQ-023 Decode SHALL be combinational: (instr & 0xFE00707F)==0x0000000B -> MV_V_X (accept=1, writeback=0); ==0x0000100B -> MV_X_V (accept=1, writeback=1); else accept=0, writeback=0.
REQ-024 Field use SHALL be: MV_V_X vd=instr[11:7], data=rs1; MV_X_V rd=instr[11:7], vs2=instr[24:20]; vreg index taken modulo NrVregs.
REQ-025 issue_ready_o SHALL be 1 iff queue not full and (decode not accepting or issue_rs_valid_i=1); no same-cycle bypass of a pop into a full queue.
REQ-026 On issue handshake with accept=1 SHALL enqueue {op, id, reg fields, rs1, committed=0, killed=0}; accept=0 handshake enqueues nothing.
REQ-027 Commit message SHALL set committed (kill=0) or killed (kill=1) on every valid queue entry with matching id, including an entry enqueued the same cycle; non-matching id SHALL be ignored.
REQ-028 Head entry SHALL retire strictly in order, only when committed or killed; at most one retire per cycle.
REQ-029 Killed head SHALL pop next edge with no vreg write and no result.
REQ-030 Committed MV_V_X head SHALL write rs1 to vreg[vd] and pop on the same edge.
REQ-031 Committed MV_X_V head SHALL load result register with vreg[vs2], id, rd on an edge when result register is empty or being drained, and pop on that edge; result_valid_o rises next cycle.
REQ-032 Vreg read for MV_X_V SHALL see all writes of older MV_V_X entries (in-order retirement guarantees it; no forwarding needed).
REQ-033 result_valid_o and all result_* SHALL stay stable until result_valid_o & result_ready_i; new result may load on the handshake edge (back-to-back 1/cycle).
REQ-034 Latency: commit at edge N of a head MV_X_V with result path free -> result_valid_o=1 in cycle after edge N+1.
REQ-035 Simultaneous enqueue and pop SHALL both occur; count unchanged; pointers wrap modulo QueueDepth.

Reset
REQ-036 rst_ni low SHALL asynchronously empty queue, clear all vregs to 0, clear result_valid_o; result_* data outputs SHALL be 0; issue_ready_o=1 after reset.
REQ-037 Reset mid-operation SHALL discard pending entries and any unaccepted result with no further outputs.

Verification
REQ-038 Issue MV_V_X 0x0000000B|vd=3, rs1=0xDEAD, commit id -> then MV_X_V vs2=3 rd=5 commit -> result_data_o=0xDEAD, rd=5, we=1.
REQ-039 Issue instr 0x00000033 -> issue_accept_o=0, issue_writeback_o=0, queue count unchanged.
REQ-040 Fill 4 entries uncommitted -> issue_ready_o=0; commit id of head -> ready returns 1 after pop.
REQ-041 Kill head MV_V_X vd=7 rs1=0x55 -> vreg[7] stays 0 (later MV_X_V vs2=7 returns 0).
REQ-042 Hold result_ready_i=0 5 cycles with result pending -> outputs stable; second committed MV_X_V waits at head.
REQ-043 Assert rst_ni=0 with 3 entries and result_valid_o=1 -> result_valid_o=0 immediately, issue_ready_o=1 after release.
